i2c_target_rx: RTL and testbench

Write-only I2C target (responder) that receives bytes from the codebase's I2C master transmitter or any standard master. It oversamples the SCL/SDA pins on the system clock, detects START and STOP, matches a 7-bit address and ACKs it. It shifts in data bytes and hands each byte to local logic with a one-cycle valid strobe. It sits between the board I2C pins, through an open-drain pad with SDA pulled low when `sda_oe`=1, and the register/config logic fed by the serial controller.

---
 rtl/i2c_target_rx.sv | 125 ++++++++++++
 tb/tb_i2c_target_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target with oversampled pins,
// 7-bit address match, ACK generation and byte hand-off.
module i2c_target_rx #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   input  logic       sda,
   input  logic       rx_ready,
   output logic       sda_oe,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       start_det,
   output logic       stop_det,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   state_t     state;
   logic [2:0] scl_q;
   logic [2:0] sda_q;
   logic [7:0] sr;
   logic [3:0] cnt;

   logic       scl_hi;
   logic       start_c;
   logic       stop_c;
   logic       rise;
   logic       fall;
   logic       in_ack;
   logic       addr_ok;
   logic [7:0] byte_c;

   // bit 1 is the synchronized level, bit 2 the previous one
   assign scl_hi  = scl_q[1] & scl_q[2];
   assign start_c = scl_hi & sda_q[2] & ~sda_q[1];
   assign stop_c  = scl_hi & ~sda_q[2] & sda_q[1];
   assign rise    = scl_q[1] & ~scl_q[2];
   assign fall    = ~scl_q[1] & scl_q[2];
   assign byte_c  = {sr[6:0], sda_q[1]};
   assign addr_ok = (sr[7:1] == ADDR) && !sr[0];
   assign in_ack  = (state == S_ADDR_ACK) ||
                    (state == S_DATA_ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         scl_q      <= 3'b111;
         sda_q      <= 3'b111;
         sr         <= 8'h00;
         cnt        <= 4'd0;
         sda_oe     <= 1'b0;
         data       <= 8'h00;
         data_valid <= 1'b0;
         start_det  <= 1'b0;
         stop_det   <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         scl_q      <= {scl_q[1:0], scl};
         sda_q      <= {sda_q[1:0], sda};
         data_valid <= 1'b0;
         start_det  <= 1'b0;
         stop_det   <= 1'b0;
         overrun    <= 1'b0;
         // one extra stage after the state gives the SDA hold time
         sda_oe     <= in_ack && !start_c && !stop_c;
         if (stop_c) begin
            state    <= S_IDLE;
            stop_det <= 1'b1;
            busy     <= 1'b0;
         end else if (start_c) begin
            state     <= S_ADDR;
            start_det <= 1'b1;
            busy      <= 1'b1;
            cnt       <= 4'd0;
            sr        <= 8'h00;
         end else begin
            unique case (state)
               S_ADDR, S_DATA: begin
                  if (rise && cnt != 4'd8) begin
                     sr  <= byte_c;
                     cnt <= cnt + 4'd1;
                     if (state == S_DATA && cnt == 4'd7) begin
                        if (rx_ready) begin
                           data       <= byte_c;
                           data_valid <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                           state   <= S_IGNORE;
                        end
                     end
                  end else if (fall && cnt == 4'd8) begin
                     if (state == S_DATA)
                        state <= S_DATA_ACK;
                     else if (addr_ok)
                        state <= S_ADDR_ACK;
                     else
                        state <= S_IGNORE;
                  end
               end
               S_ADDR_ACK, S_DATA_ACK: begin
                  if (fall) begin
                     state <= S_DATA;
                     cnt   <= 4'd0;
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: directed I2C write transactions against a
// transaction-level model of the target's expected behaviour.
module tb_i2c_target_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       rx_ready = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] data;
   logic       data_valid;
   logic       start_det;
   logic       stop_det;
   logic       overrun;
   logic       busy;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_rx #(.ADDR(7'h50)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl        (scl),
      .sda        (sda_line),
      .rx_ready   (rx_ready),
      .sda_oe     (sda_oe),
      .data       (data),
      .data_valid (data_valid),
      .start_det  (start_det),
      .stop_det   (stop_det),
      .overrun    (overrun),
      .busy       (busy)
   );

   int vec = 0;
   int errs = 0;
   int obs_start = 0, obs_stop = 0, obs_valid = 0, obs_ovr = 0;
   int exp_start = 0, exp_stop = 0, exp_valid = 0, exp_ovr = 0;
   int mode = 0;
   logic [7:0] expq[$];
   logic [7:0] last_data = 8'h00;
   bit data_phase = 0, ack_phase = 0, exp_ack = 0;
   bit prev_sd = 0, prev_pd = 0, prev_dv = 0, prev_ov = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      vec++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // per-cycle compare against the transaction model
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         last_data = data;
         prev_sd = 0; prev_pd = 0; prev_dv = 0; prev_ov = 0;
      end else begin
         if (data_valid) begin
            obs_valid++;
            check("valid_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
               check("data", data, expq[0]);
               void'(expq.pop_front());
            end
            check("valid_width", prev_dv, 0);
         end else begin
            check("data_hold", data, last_data);
         end
         last_data = data;
         if (start_det) begin
            obs_start++;
            check("start_width", prev_sd, 0);
         end
         if (stop_det) begin
            obs_stop++;
            check("stop_width", prev_pd, 0);
         end
         if (overrun) begin
            obs_ovr++;
            check("ovr_width", prev_ov, 0);
         end
         prev_sd = start_det; prev_pd = stop_det;
         prev_dv = data_valid; prev_ov = overrun;
         if (data_phase) check("oe_data", sda_oe, 0);
         if (ack_phase) begin
            check("oe_ack", sda_oe, exp_ack);
            check("busy_xfer", busy, 1);
         end
      end
   end

   task automatic start(input bit chk);
      sda_m = 1; tick(3);
      scl = 1; tick(6);
      sda_m = 0;
      exp_start++;
      mode = 1;
      if (chk) begin
         repeat (2) @(posedge clk);
         #1 check("start_lat_early", start_det, 0);
         @(posedge clk);
         #1 check("start_lat", start_det, 1);
         tick(6);
      end else begin
         tick(8);
      end
      scl = 0; tick(5);
   endtask

   task automatic stop();
      sda_m = 0; tick(3);
      scl = 1; tick(6);
      sda_m = 1;
      exp_stop++;
      mode = 0;
      tick(8);
   endtask

   task automatic wbit(input logic b);
      sda_m = b; tick(3);
      scl = 1; data_phase = 1; tick(8);
      data_phase = 0; scl = 0; tick(5);
   endtask

   task automatic wbyte(input logic [7:0] b, input bit chk,
                        input bit rst_ack);
      bit a;
      case (mode)
         1: begin
            a = (b[7:1] == 7'h50) && !b[0];
            mode = a ? 2 : 0;
         end
         2: begin
            a = rx_ready;
            if (a) begin
               expq.push_back(b);
               exp_valid++;
            end else begin
               exp_ovr++;
               mode = 0;
            end
         end
         default: a = 0;
      endcase
      for (int i = 7; i >= 1; i--) wbit(b[i]);
      sda_m = b[0]; tick(3);
      scl = 1; data_phase = 1; tick(8);
      data_phase = 0; scl = 0;
      if (chk) begin
         repeat (3) @(posedge clk);
         #1 check("oe_rise_early", sda_oe, 0);
         @(posedge clk);
         #1 check("oe_rise", sda_oe, a);
         tick(2);
      end else begin
         tick(5);
      end
      sda_m = 1; tick(3);
      scl = 1; exp_ack = a; ack_phase = 1;
      if (!rst_ack) begin
         tick(8);
         ack_phase = 0;
         check("ack_line", !sda_line, a);
         scl = 0;
         if (chk) begin
            repeat (3) @(posedge clk);
            #1 check("oe_fall_early", sda_oe, a);
            @(posedge clk);
            #1 check("oe_fall", sda_oe, 0);
            tick(2);
         end else begin
            tick(5);
         end
      end else begin
         tick(4);
         ack_phase = 0;
         rst_n = 0;
         #1;
         check("rst_oe_async", sda_oe, 0);
         check("rst_outs", {data, data_valid, start_det,
                            stop_det, overrun, busy}, 0);
         mode = 0;
         tick(4);
         scl = 0; tick(3);
         rst_n = 1; tick(5);
      end
   endtask

   task automatic scen_chk(input string tag);
      check({tag, "_n_start"}, obs_start, exp_start);
      check({tag, "_n_stop"}, obs_stop, exp_stop);
      check({tag, "_n_valid"}, obs_valid, exp_valid);
      check({tag, "_n_ovr"}, obs_ovr, exp_ovr);
      check({tag, "_q_empty"}, expq.size(), 0);
      check({tag, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      tick(3);
      check("reset_oe", sda_oe, 0);
      check("reset_outs", {data, data_valid, start_det,
                           stop_det, overrun, busy}, 0);
      rst_n = 1; tick(5);

      // accepted write of one byte
      rx_ready = 1;
      start(1);
      wbyte(8'hA0, 1, 0);
      wbyte(8'hA5, 1, 0);
      check("s1_busy_on", busy, 1);
      stop();
      scen_chk("s1");
      check("s1_data", data, 8'hA5);
      check("s1_valid", obs_valid, 1);
      check("s1_start", obs_start, 1);
      check("s1_stop", obs_stop, 1);

      // wrong address
      start(0);
      wbyte(8'hA2, 0, 0);
      wbyte(8'h3C, 0, 0);
      stop();
      scen_chk("s2");
      check("s2_valid", obs_valid, 1);
      check("s2_stop", obs_stop, 2);

      // read request is not acknowledged
      start(0);
      wbyte(8'hA1, 1, 0);
      wbyte(8'h55, 0, 0);
      stop();
      scen_chk("s3");
      check("s3_valid", obs_valid, 1);
      check("s3_data", data, 8'hA5);

      // overrun
      start(0);
      wbyte(8'hA0, 0, 0);
      rx_ready = 1;
      wbyte(8'h11, 0, 0);
      rx_ready = 0;
      wbyte(8'h22, 0, 0);
      rx_ready = 1;
      wbyte(8'h33, 0, 0);
      stop();
      scen_chk("s4");
      check("s4_data", data, 8'h11);
      check("s4_ovr", obs_ovr, 1);
      check("s4_valid", obs_valid, 2);

      // partial byte then repeated START
      start(0);
      wbyte(8'hA0, 0, 0);
      wbit(1); wbit(0); wbit(1); wbit(0);
      start(1);
      wbyte(8'hA0, 0, 0);
      wbyte(8'h7E, 0, 0);
      stop();
      scen_chk("s5");
      check("s5_start", obs_start, 6);
      check("s5_valid", obs_valid, 3);
      check("s5_data", data, 8'h7E);

      // reset inside the address ACK window
      start(0);
      wbyte(8'hA0, 0, 1);
      check("s6_data_rst", data, 8'h00);
      stop();
      start(0);
      wbyte(8'hA0, 1, 0);
      wbyte(8'h5A, 1, 0);
      stop();
      scen_chk("s6");
      check("s6_data", data, 8'h5A);
      check("s6_valid", obs_valid, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
